prod_accum: RTL
===============

PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter N, default 4: operand width of the upstream multiplier; the product input is 2N bits.
REQ-002 Parameter CNT, default 8: number of products per accumulation frame, legal range 2..255.
REQ-003 Parameter ACC_W, default 12: accumulator and result width, ACC_W SHALL be >= 2N.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clear  input  1  synchronous frame abort, active-high.
REQ-007 in_valid  input  1  prod is valid this cycle.
REQ-008 prod  input  2N  unsigned product from the upstream multiplier stage.
REQ-009 sum  output  ACC_W  registered frame result.
REQ-010 sum_valid  output  1  one-cycle pulse marking a new sum.
REQ-011 ovf  output  1  wrap-around occurred in the frame that produced the current sum.
REQ-012 busy  output  1  high while a frame is partially accumulated (state ACC).

Function
REQ-013 The FSM SHALL have two states: IDLE (no frame open) and ACC (frame open).
REQ-014 IDLE with in_valid=1 and clear=0: acc <= prod (zero-extended), count <= 1, ovf_run <= 0, go to ACC.
REQ-015 ACC with in_valid=1 and clear=0: acc <= acc + prod modulo 2^ACC_W, count <= count+1; ovf_run SHALL set sticky if the add carries out of bit ACC_W-1.
REQ-016 in_valid=0 SHALL hold acc, count, ovf_run, and state unchanged; gaps within a frame are legal.
REQ-017 On the edge that accepts the CNT-th product: sum <= final accumulated value, ovf <= final sticky flag, state <= IDLE, and sum_valid SHALL be 1 for exactly the following cycle.
REQ-018 Latency: sum and sum_valid SHALL appear one clock after the last product is sampled; no additional pipeline stage.
REQ-019 in_valid=1 during the cycle that sum_valid=1 SHALL start the next frame (IDLE path), allowing back-to-back frames with no bubble.
REQ-020 sum and ovf SHALL hold their values until the next frame completes; sum_valid SHALL otherwise be 0.
REQ-021 clear=1 SHALL take priority over in_valid: discard the open frame, acc <= 0, count <= 0, ovf_run <= 0, and go to IDLE; sum and ovf SHALL be unaffected; no sum_valid pulse.
REQ-022 busy SHALL equal (state == ACC) and is registered.
REQ-023 count SHALL be wide enough for CNT and SHALL never exceed CNT.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, acc 0, count 0, ovf_run 0, sum 0, sum_valid 0, ovf 0, busy 0.
REQ-025 Reset asserted mid-frame SHALL discard partial data; the first in_valid after release starts a fresh frame.
REQ-026 Release SHALL take effect on the first rising clk edge with rst_n=1.

Verification
REQ-027 Defaults; 8 consecutive in_valid with prod=10 -> sum=80, ovf=0, sum_valid high for one cycle right after the 8th product edge, busy low afterward.
REQ-028 Defaults; 8 products of 225 (15x15) with 1-3 idle cycles between them -> sum=1800, ovf=0; busy stays high through the gaps.
REQ-029 ACC_W=10; 8 products of 225 -> sum=776 (1800 mod 1024), ovf=1; next frame of 8x1 -> sum=8, ovf=0.
REQ-030 Defaults; 16 back-to-back products, first 8 = 10 and next 8 = 20 -> two sum_valid pulses 8 cycles apart, sum=80 then 160.
REQ-031 Defaults; 5 products of 8, then clear together with in_valid, then 8 products of 3 -> the clear-cycle product is dropped, no pulse for the aborted frame, next sum=24.
REQ-032 Defaults; rst_n pulsed low for 3 ns after 4 products -> all outputs 0 asynchronously; a following 8x5 frame gives sum=40.

Source files
------------

// File: rtl/prod_accum_if.sv
// Handshake and result bundle between a product source and the prod_accum frame accumulator.
interface prod_accum_if #(
    parameter int N     = 4,
    parameter int ACC_W = 12
);
    logic             clear;
    logic             in_valid;
    logic [2*N-1:0]   prod;
    logic [ACC_W-1:0] sum;
    logic             sum_valid;
    logic             ovf;
    logic             busy;

    modport master (output clear, in_valid, prod, input sum, sum_valid, ovf, busy);
    modport slave  (input clear, in_valid, prod, output sum, sum_valid, ovf, busy);
endinterface

// File: rtl/prod_accum.sv
// Accumulates CNT unsigned products per frame and publishes a registered sum with a sticky wrap flag.
//   state  | meaning
//   S_IDLE | no frame open; next valid product starts a frame
//   S_ACC  | frame open; products accumulate until the CNT-th arrives
module prod_accum #(
    parameter int N     = 4,
    parameter int CNT   = 8,
    parameter int ACC_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    prod_accum_if.slave bus
);
    localparam int CW = $clog2(CNT + 1);
    localparam logic [CW-1:0] LAST = CW'(CNT - 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACC  = 1'b1;

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]    count;
    logic             ovf_run;
    logic [ACC_W-1:0] sum_r;
    logic             sum_valid_r;
    logic             ovf_r;
    logic [ACC_W:0]   add_full;

    // One spare bit on top catches the carry out of the accumulator.
    assign add_full = {1'b0, acc} + (ACC_W + 1)'(bus.prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            acc         <= '0;
            count       <= '0;
            ovf_run     <= 1'b0;
            sum_r       <= '0;
            sum_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            sum_valid_r <= 1'b0;
            if (bus.clear) begin
                state   <= S_IDLE;
                acc     <= '0;
                count   <= '0;
                ovf_run <= 1'b0;
            end else if (bus.in_valid) begin
                case (state)
                    S_IDLE: begin
                        acc     <= ACC_W'(bus.prod);
                        count   <= CW'(1);
                        ovf_run <= 1'b0;
                        state   <= S_ACC;
                    end
                    default: begin
                        if (count == LAST) begin
                            sum_r       <= add_full[ACC_W-1:0];
                            ovf_r       <= ovf_run | add_full[ACC_W];
                            sum_valid_r <= 1'b1;
                            acc         <= '0;
                            count       <= '0;
                            ovf_run     <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            acc     <= add_full[ACC_W-1:0];
                            count   <= count + 1'b1;
                            ovf_run <= ovf_run | add_full[ACC_W];
                        end
                    end
                endcase
            end
        end
    end

    assign bus.sum       = sum_r;
    assign bus.sum_valid = sum_valid_r;
    assign bus.ovf       = ovf_r;
    assign bus.busy      = (state == S_ACC);
endmodule
